// File: rtl/ide_cycle_ctrl_pkg.sv
// Shared definitions for the IDE / boot-ROM bus-cycle engine:
// FSM state encoding and the address bits the decoder looks at.
package ide_cycle_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STROBE = 3'd2,
        ST_HOLD   = 3'd3,
        ST_ACK    = 3'd4,
        ST_ROM    = 3'd5
    } cycle_state_t;

    // Bit positions within ADDR[16:1]
    localparam int SEL_BIT = 16;
    localparam int CS_BIT  = 12;
    localparam int DA_MSB  = 11;
    localparam int DA_LSB  = 9;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ide_cycle_ctrl_if.sv
// CPU-side request/acknowledge signals plus the ATA and boot-ROM strobes
// handled by the cycle engine.
interface ide_cycle_ctrl_if;

    logic [16:1] ADDR;
    logic        AS_n;
    logic        UDS_n;
    logic        LDS_n;
    logic        RW;
    logic        ide_access;
    logic        IDE_IORDY;
    logic        IDE_CS0_n;
    logic        IDE_CS1_n;
    logic [2:0]  IDE_DA;
    logic        IDE_IOR_n;
    logic        IDE_IOW_n;
    logic        ROM_OE_n;
    logic        ROM_WE_n;
    logic        dtack;
    logic        timeout;

    modport slave (
        input  ADDR, AS_n, UDS_n, LDS_n, RW, ide_access, IDE_IORDY,
        output IDE_CS0_n, IDE_CS1_n, IDE_DA, IDE_IOR_n, IDE_IOW_n,
               ROM_OE_n, ROM_WE_n, dtack, timeout
    );

    modport master (
        output ADDR, AS_n, UDS_n, LDS_n, RW, ide_access, IDE_IORDY,
        input  IDE_CS0_n, IDE_CS1_n, IDE_DA, IDE_IOR_n, IDE_IOW_n,
               ROM_OE_n, ROM_WE_n, dtack, timeout
    );

endinterface

// File: rtl/ide_cycle_ctrl.sv
// Turns 68000 bus cycles in the board window into ATA PIO or boot-ROM strobes,
// sequencing setup/strobe/hold in CLKs and stretching the strobe on IORDY.
module ide_cycle_ctrl
    import ide_cycle_ctrl_pkg::*;
#(
    parameter int SETUP_CLKS    = 1,
    parameter int STROBE_CLKS   = 2,
    parameter int HOLD_CLKS     = 1,
    parameter int ROM_CLKS      = 2,
    parameter int IORDY_TIMEOUT = 16
)
(
    input logic            CLK,
    input logic            RESET,
    ide_cycle_ctrl_if.slave bus
);

    localparam int MAX_CLKS = max_int(max_int(max_int(SETUP_CLKS, STROBE_CLKS),
                                              max_int(HOLD_CLKS, ROM_CLKS)),
                                      IORDY_TIMEOUT);
    localparam int CNT_W = $clog2(MAX_CLKS + 1);

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t SETUP_LOAD   = cnt_t'(SETUP_CLKS - 1);
    localparam cnt_t STROBE_LOAD  = cnt_t'(STROBE_CLKS - 1);
    localparam cnt_t HOLD_LOAD    = cnt_t'(HOLD_CLKS - 1);
    localparam cnt_t ROM_LOAD     = cnt_t'(ROM_CLKS - 1);
    localparam cnt_t TIMEOUT_LOAD = cnt_t'((IORDY_TIMEOUT > 0) ? IORDY_TIMEOUT - 1 : 0);

    cycle_state_t state_q, state_d;
    cnt_t         cnt_q, cnt_d;
    logic         stretch_q, stretch_d;
    logic         abort_q, abort_d;
    logic         cs1_q, cs1_d;
    logic [2:0]   da_q, da_d;
    logic         rw_q, rw_d;

    logic         cs0_n_q, cs0_n_d;
    logic         cs1_n_q, cs1_n_d;
    logic [2:0]   da_out_q, da_out_d;
    logic         ior_n_q, ior_n_d;
    logic         iow_n_q, iow_n_d;
    logic         oe_n_q, oe_n_d;
    logic         we_n_q, we_n_d;
    logic         dtack_q, dtack_d;
    logic         timeout_q, timeout_d;

    logic         start;
    logic         cs_active;
    logic         unused_addr_bits;

    assign unused_addr_bits = ^{bus.ADDR[15:13], bus.ADDR[8:1]};

    assign start = bus.ide_access & ~bus.AS_n & (~bus.UDS_n | ~bus.LDS_n);

    // Outputs are decoded from the next state so every strobe comes straight off a flop.
    always_comb begin
        state_d   = state_q;
        cnt_d     = (cnt_q == '0) ? '0 : cnt_q - 1'b1;
        stretch_d = stretch_q;
        abort_d   = abort_q;
        cs1_d     = cs1_q;
        da_d      = da_q;
        rw_d      = rw_q;
        timeout_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                stretch_d = 1'b0;
                abort_d   = 1'b0;
                if (start) begin
                    cs1_d = bus.ADDR[CS_BIT];
                    da_d  = bus.ADDR[DA_MSB:DA_LSB];
                    rw_d  = bus.RW;
                    if (bus.ADDR[SEL_BIT]) begin
                        state_d = ST_SETUP;
                        cnt_d   = SETUP_LOAD;
                    end else begin
                        state_d = ST_ROM;
                        cnt_d   = ROM_LOAD;
                    end
                end
            end

            ST_SETUP: begin
                if (bus.AS_n) begin
                    state_d = ST_HOLD;
                    cnt_d   = HOLD_LOAD;
                    abort_d = 1'b1;
                end else if (cnt_q == '0) begin
                    state_d   = ST_STROBE;
                    cnt_d     = STROBE_LOAD;
                    stretch_d = 1'b0;
                end
            end

            // The counter first times the minimum strobe, then is reloaded for the IORDY stretch.
            ST_STROBE: begin
                if (bus.AS_n) begin
                    state_d = ST_HOLD;
                    cnt_d   = HOLD_LOAD;
                    abort_d = 1'b1;
                end else if (stretch_q) begin
                    if (bus.IDE_IORDY) begin
                        state_d = ST_HOLD;
                        cnt_d   = HOLD_LOAD;
                    end else if (cnt_q == '0) begin
                        state_d   = ST_HOLD;
                        cnt_d     = HOLD_LOAD;
                        timeout_d = 1'b1;
                    end
                end else if (cnt_q == '0) begin
                    if (bus.IDE_IORDY) begin
                        state_d = ST_HOLD;
                        cnt_d   = HOLD_LOAD;
                    end else if (IORDY_TIMEOUT == 0) begin
                        state_d   = ST_HOLD;
                        cnt_d     = HOLD_LOAD;
                        timeout_d = 1'b1;
                    end else begin
                        stretch_d = 1'b1;
                        cnt_d     = TIMEOUT_LOAD;
                    end
                end
            end

            ST_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = abort_q ? ST_IDLE : ST_ACK;
                    cnt_d   = '0;
                end
            end

            ST_ACK: begin
                if (bus.AS_n) begin
                    state_d = ST_IDLE;
                end
            end

            ST_ROM: begin
                if (bus.AS_n) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = ST_ACK;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        cs_active = (state_d == ST_SETUP) || (state_d == ST_STROBE) || (state_d == ST_HOLD);
        cs0_n_d   = ~(cs_active & ~cs1_d);
        cs1_n_d   = ~(cs_active & cs1_d);
        da_out_d  = cs_active ? da_d : 3'd0;
        ior_n_d   = ~((state_d == ST_STROBE) & rw_d);
        iow_n_d   = ~((state_d == ST_STROBE) & ~rw_d);
        oe_n_d    = ~((state_d == ST_ROM) & rw_d);
        we_n_d    = ~((state_d == ST_ROM) & ~rw_d);
        dtack_d   = (state_d == ST_ACK);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            stretch_q <= 1'b0;
            abort_q   <= 1'b0;
            cs1_q     <= 1'b0;
            da_q      <= 3'd0;
            rw_q      <= 1'b1;
            cs0_n_q   <= 1'b1;
            cs1_n_q   <= 1'b1;
            da_out_q  <= 3'd0;
            ior_n_q   <= 1'b1;
            iow_n_q   <= 1'b1;
            oe_n_q    <= 1'b1;
            we_n_q    <= 1'b1;
            dtack_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            stretch_q <= stretch_d;
            abort_q   <= abort_d;
            cs1_q     <= cs1_d;
            da_q      <= da_d;
            rw_q      <= rw_d;
            cs0_n_q   <= cs0_n_d;
            cs1_n_q   <= cs1_n_d;
            da_out_q  <= da_out_d;
            ior_n_q   <= ior_n_d;
            iow_n_q   <= iow_n_d;
            oe_n_q    <= oe_n_d;
            we_n_q    <= we_n_d;
            dtack_q   <= dtack_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.IDE_CS0_n = cs0_n_q;
    assign bus.IDE_CS1_n = cs1_n_q;
    assign bus.IDE_DA    = da_out_q;
    assign bus.IDE_IOR_n = ior_n_q;
    assign bus.IDE_IOW_n = iow_n_q;
    assign bus.ROM_OE_n  = oe_n_q;
    assign bus.ROM_WE_n  = we_n_q;
    assign bus.dtack     = dtack_q;
    assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_ide_cycle_ctrl.sv
// Self-checking bench for ide_cycle_ctrl: each bus cycle pushes a modelled
// strobe/timing profile to a queue, which is compared against what was observed.
module tb_ide_cycle_ctrl;

    localparam int SETUP_CLKS    = 1;
    localparam int STROBE_CLKS   = 2;
    localparam int HOLD_CLKS     = 1;
    localparam int ROM_CLKS      = 2;
    localparam int IORDY_TIMEOUT = 16;

    logic CLK = 1'b0;
    logic RESET;

    ide_cycle_ctrl_if bus();

    ide_cycle_ctrl #(
        .SETUP_CLKS   (SETUP_CLKS),
        .STROBE_CLKS  (STROBE_CLKS),
        .HOLD_CLKS    (HOLD_CLKS),
        .ROM_CLKS     (ROM_CLKS),
        .IORDY_TIMEOUT(IORDY_TIMEOUT)
    ) dut (
        .CLK  (CLK),
        .RESET(RESET),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int firstSel;
        int cs0Len;
        int cs1Len;
        int da;
        int iorLen;
        int iowLen;
        int oeLen;
        int weLen;
        int toCnt;
        int strobeOff;
        int dtackOff;
        int dtackLen;
    } profile_t;

    profile_t expQ[$];
    int checkCnt = 0;
    int passCnt  = 0;

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checkCnt++;
        if (actual == expected) begin
            passCnt++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Reference model of one bus cycle, derived from the timing parameters.
    function automatic profile_t buildExpected(input logic isIde, input logic cs1,
                                               input logic [2:0] da, input logic rw,
                                               input int stretch, input int abortAfter);
        profile_t e;
        int stLen;
        int csLen;
        e.firstSel = 0;
        e.toCnt    = 0;
        if (isIde) begin
            if (abortAfter > 0) begin
                stLen = abortAfter;
            end else if (stretch < 0 || stretch > IORDY_TIMEOUT) begin
                stLen   = STROBE_CLKS + IORDY_TIMEOUT;
                e.toCnt = 1;
            end else begin
                stLen = STROBE_CLKS + stretch;
            end
            csLen       = SETUP_CLKS + stLen + HOLD_CLKS;
            e.cs0Len    = cs1 ? 0 : csLen;
            e.cs1Len    = cs1 ? csLen : 0;
            e.da        = int'(da);
            e.iorLen    = rw ? stLen : 0;
            e.iowLen    = rw ? 0 : stLen;
            e.oeLen     = 0;
            e.weLen     = 0;
            e.strobeOff = SETUP_CLKS;
            e.dtackOff  = (abortAfter > 0) ? -1 : csLen;
            e.dtackLen  = (abortAfter > 0) ? 0 : 1;
        end else begin
            e.cs0Len    = 0;
            e.cs1Len    = 0;
            e.da        = -1;
            e.iorLen    = 0;
            e.iowLen    = 0;
            e.oeLen     = rw ? ROM_CLKS : 0;
            e.weLen     = rw ? 0 : ROM_CLKS;
            e.strobeOff = -1;
            e.dtackOff  = ROM_CLKS;
            e.dtackLen  = 1;
        end
        return e;
    endfunction

    task automatic compareProfile(input string tag, input profile_t got, input profile_t want);
        checkOutput({tag, ".firstSel"},  got.firstSel,  want.firstSel);
        checkOutput({tag, ".cs0Len"},    got.cs0Len,    want.cs0Len);
        checkOutput({tag, ".cs1Len"},    got.cs1Len,    want.cs1Len);
        checkOutput({tag, ".da"},        got.da,        want.da);
        checkOutput({tag, ".iorLen"},    got.iorLen,    want.iorLen);
        checkOutput({tag, ".iowLen"},    got.iowLen,    want.iowLen);
        checkOutput({tag, ".oeLen"},     got.oeLen,     want.oeLen);
        checkOutput({tag, ".weLen"},     got.weLen,     want.weLen);
        checkOutput({tag, ".timeout"},   got.toCnt,     want.toCnt);
        checkOutput({tag, ".strobeOff"}, got.strobeOff, want.strobeOff);
        checkOutput({tag, ".dtackOff"},  got.dtackOff,  want.dtackOff);
        checkOutput({tag, ".dtackLen"},  got.dtackLen,  want.dtackLen);
    endtask

    // Runs one CPU cycle; stretch = IORDY-low samples after the minimum strobe (-1 = forever).
    task automatic applyStimulus(input string tag, input logic isIde, input logic cs1,
                                 input logic [2:0] da, input logic rw, input int stretch,
                                 input int abortAfter, input logic dropAccess, input logic useLds);
        profile_t got;
        profile_t want;
        logic [16:1] a;
        int t;
        int tail;
        int strobeCnt;
        int firstStrobe;
        int firstDtack;
        logic asRaised;

        @(negedge CLK);
        a = 16'($urandom);
        a[16] = isIde;
        a[12] = cs1;
        a[11:9] = da;
        bus.ADDR       = a;
        bus.RW         = rw;
        bus.ide_access = 1'b1;
        bus.AS_n       = 1'b0;
        bus.UDS_n      = useLds;
        bus.LDS_n      = ~useLds;
        bus.IDE_IORDY  = (stretch == 0);
        expQ.push_back(buildExpected(isIde, cs1, da, rw, stretch, abortAfter));

        got = '{firstSel: -1, da: -1, default: 0};
        t = 0;
        tail = 0;
        firstStrobe = -1;
        firstDtack = -1;
        asRaised = 1'b0;
        while (tail < 4 && t < 60) begin
            @(negedge CLK);
            if (got.firstSel < 0 && (!bus.IDE_CS0_n || !bus.IDE_CS1_n || !bus.ROM_OE_n || !bus.ROM_WE_n)) begin
                got.firstSel = t;
                if (!bus.IDE_CS0_n || !bus.IDE_CS1_n) got.da = int'(bus.IDE_DA);
            end
            if (!bus.IDE_CS0_n) got.cs0Len++;
            if (!bus.IDE_CS1_n) got.cs1Len++;
            if (!bus.IDE_IOR_n) got.iorLen++;
            if (!bus.IDE_IOW_n) got.iowLen++;
            if (!bus.ROM_OE_n)  got.oeLen++;
            if (!bus.ROM_WE_n)  got.weLen++;
            if (bus.timeout)    got.toCnt++;
            if (firstStrobe < 0 && (!bus.IDE_IOR_n || !bus.IDE_IOW_n)) firstStrobe = t;
            if (bus.dtack) begin
                got.dtackLen++;
                if (firstDtack < 0) firstDtack = t;
            end
            strobeCnt = got.iorLen + got.iowLen;
            if (dropAccess && t == 0) bus.ide_access = 1'b0;
            if (!asRaised && ((abortAfter > 0 && strobeCnt == abortAfter) || bus.dtack)) begin
                bus.AS_n  = 1'b1;
                bus.UDS_n = 1'b1;
                bus.LDS_n = 1'b1;
                asRaised  = 1'b1;
            end
            if (stretch > 0) bus.IDE_IORDY = (strobeCnt >= STROBE_CLKS + stretch);
            if (asRaised) tail++;
            t++;
        end
        if (!asRaised) begin
            checkOutput({tag, ".cycleBudget"}, t, -1);
        end

        bus.AS_n       = 1'b1;
        bus.UDS_n      = 1'b1;
        bus.LDS_n      = 1'b1;
        bus.ide_access = 1'b0;
        bus.IDE_IORDY  = 1'b1;

        got.strobeOff = (firstStrobe >= 0 && got.firstSel >= 0) ? firstStrobe - got.firstSel : -1;
        got.dtackOff  = (firstDtack >= 0 && got.firstSel >= 0) ? firstDtack - got.firstSel : -1;
        want = expQ.pop_front();
        compareProfile(tag, got, want);
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, ".strobes"},
                    int'({bus.IDE_CS0_n, bus.IDE_CS1_n, bus.IDE_IOR_n, bus.IDE_IOW_n, bus.ROM_OE_n, bus.ROM_WE_n}),
                    63);
        checkOutput({tag, ".da"},      int'(bus.IDE_DA), 0);
        checkOutput({tag, ".dtack"},   int'(bus.dtack), 0);
        checkOutput({tag, ".timeout"}, int'(bus.timeout), 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int waitCnt;
        logic reached;

        RESET          = 1'b1;
        bus.ADDR       = '0;
        bus.RW         = 1'b1;
        bus.AS_n       = 1'b1;
        bus.UDS_n      = 1'b1;
        bus.LDS_n      = 1'b1;
        bus.ide_access = 1'b0;
        bus.IDE_IORDY  = 1'b1;
        repeat (3) @(negedge CLK);
        checkIdleOutputs("reset");
        RESET = 1'b0;
        $display("[TB] reset released");

        applyStimulus("ide_rd",      1'b1, 1'b0, 3'd5, 1'b1,  0, 0, 1'b0, 1'b0);
        applyStimulus("ide_wr",      1'b1, 1'b1, 3'd3, 1'b0,  0, 0, 1'b1, 1'b0);
        applyStimulus("iordy5",      1'b1, 1'b0, 3'd1, 1'b1,  5, 0, 1'b0, 1'b1);
        applyStimulus("iordy_to",    1'b1, 1'b0, 3'd7, 1'b1, -1, 0, 1'b0, 1'b0);
        applyStimulus("rom_rd",      1'b0, 1'b0, 3'd0, 1'b1,  0, 0, 1'b0, 1'b0);
        applyStimulus("rom_wr",      1'b0, 1'b1, 3'd2, 1'b0,  0, 0, 1'b0, 1'b1);
        applyStimulus("abort",       1'b1, 1'b0, 3'd4, 1'b1,  0, 1, 1'b0, 1'b0);
        applyStimulus("after_abort", 1'b1, 1'b1, 3'd6, 1'b0,  0, 0, 1'b0, 1'b1);

        // Reset mid-strobe, then hold AS_n low outside the window.
        @(negedge CLK);
        bus.ADDR       = 16'h8000;
        bus.RW         = 1'b1;
        bus.ide_access = 1'b1;
        bus.AS_n       = 1'b0;
        bus.UDS_n      = 1'b0;
        waitCnt = 0;
        reached = 1'b0;
        while (!reached && waitCnt < 10) begin
            @(negedge CLK);
            reached = !bus.IDE_IOR_n;
            waitCnt++;
        end
        checkOutput("rst_mid.reachStrobe", int'(reached), 1);
        RESET = 1'b1;
        @(negedge CLK);
        checkIdleOutputs("rst_mid");
        RESET = 1'b0;
        bus.ide_access = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            checkOutput("rst_after.strobes",
                        int'({bus.IDE_CS0_n, bus.IDE_CS1_n, bus.IDE_IOR_n, bus.IDE_IOW_n, bus.ROM_OE_n, bus.ROM_WE_n, ~bus.dtack}),
                        127);
        end
        bus.AS_n  = 1'b1;
        bus.UDS_n = 1'b1;
        repeat (2) @(negedge CLK);

        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule
